// File: rtl/lite16_lsu_pkg.sv
// Shared constants and types for the LITE-16 load/store unit.
package lite16_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    STORE,
    RESP
  } lsu_state_t;

  // Byte lane within a 16-bit word.
  typedef enum logic {
    LANE_LO = 1'b0,
    LANE_HI = 1'b1
  } lane_sel_t;

endpackage

// File: rtl/lite16_lsu_if.sv
// Request/response handshake bundle between the execute stage and the LSU.
interface lite16_lsu_if;
  import lite16_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_byte;
  logic              req_hi;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  // Requester side (execute stage).
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_byte, req_hi, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  // LSU side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_byte, req_hi, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/lite16_lsu_byte_lane.sv
// Combinational byte extract (zero-extended) and byte merge for sub-word access.
module lite16_lsu_byte_lane
  import lite16_mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [7:0]        wbyte,
  input  lane_sel_t         lane,
  output logic [DATA_W-1:0] extract,
  output logic [DATA_W-1:0] merged
);

  // Select the addressed lane for loads and replace it for stores.
  always_comb begin
    extract = '0;
    merged  = rdata;
    if (lane == LANE_HI) begin
      extract = {8'h00, rdata[15:8]};
      merged  = {wbyte, rdata[7:0]};
    end else begin
      extract = {8'h00, rdata[7:0]};
      merged  = {rdata[15:8], wbyte};
    end
  end

endmodule

// File: rtl/lite16_lsu.sv
// LITE-16 load/store unit: one request at a time, drives the word RAM and
// returns load data or a store completion over a valid/ready response.
// Optional byte access (byte load extract, byte store read-modify-write)
// is enabled by defining LSU_BYTE_ACCESS_EN.
module lite16_lsu
  import lite16_mem_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  lite16_lsu_if.slave       bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_store,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t state;
  logic [1:0] cnt;

`ifdef LSU_BYTE_ACCESS_EN
  logic              lat_we;
  logic              lat_byte;
  lane_sel_t         lat_lane;
  logic [7:0]        lat_wbyte;
  logic [DATA_W-1:0] lane_extract;
  logic [DATA_W-1:0] lane_merged;

  lite16_lsu_byte_lane u_byte_lane (
    .rdata   (mem_rdata),
    .wbyte   (lat_wbyte),
    .lane    (lat_lane),
    .extract (lane_extract),
    .merged  (lane_merged)
  );
`else
  logic unused_byte_pins;
  assign unused_byte_pins = bus.req_byte ^ bus.req_hi;
`endif

  // Main controller; every mem_* and resp_* output is a register set on the
  // transition into the state that owns it, so nothing from req_* leaks
  // combinationally onto the RAM pins. mem_addr doubles as the latched address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_store      <= 1'b0;
      mem_load       <= 1'b0;
`ifdef LSU_BYTE_ACCESS_EN
      lat_we         <= 1'b0;
      lat_byte       <= 1'b0;
      lat_lane       <= LANE_LO;
      lat_wbyte      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // req_ready rises on the first edge after reset release.
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            mem_addr      <= bus.req_addr;
            mem_wdata     <= bus.req_wdata;
`ifdef LSU_BYTE_ACCESS_EN
            lat_we    <= bus.req_we;
            lat_byte  <= bus.req_byte;
            lat_lane  <= bus.req_hi ? LANE_HI : LANE_LO;
            lat_wbyte <= bus.req_wdata[7:0];
            if (bus.req_we && !bus.req_byte) begin
              mem_store <= 1'b1;
              state     <= STORE;
            end else begin
              mem_load <= 1'b1;
              state    <= LOAD;
            end
`else
            if (bus.req_we) begin
              mem_store <= 1'b1;
              state     <= STORE;
            end else begin
              mem_load <= 1'b1;
              state    <= LOAD;
            end
`endif
          end
        end

        LOAD: begin
          mem_load <= 1'b0;
          cnt      <= 2'(RD_LATENCY - 1);
          state    <= WAIT;
        end

        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 2'd1;
          end else begin
`ifdef LSU_BYTE_ACCESS_EN
            if (lat_byte && lat_we) begin
              mem_wdata <= lane_merged;
              mem_store <= 1'b1;
              state     <= STORE;
            end else begin
              bus.resp_rdata <= lat_byte ? lane_extract : mem_rdata;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end
`else
            bus.resp_rdata <= mem_rdata;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
`endif
          end
        end

        STORE: begin
          mem_store      <= 1'b0;
          bus.resp_rdata <= '0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end

        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lite16_lsu.sv
// Bench for lite16_lsu: two instances (RD_LATENCY 1 and 3), each with a
// latency-accurate RAM, a transaction-level reference model and a per-cycle
// compare process, plus directed requests with literal expectations.
module tb_lite16_lsu;
  import lite16_mem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  lite16_lsu_if bus0 ();
  lite16_lsu_if bus1 ();

  logic [15:0] m_addr0, m_wdata0, m_rdata0, m_addr1, m_wdata1, m_rdata1;
  logic        m_store0, m_load0, m_store1, m_load1;

  lite16_lsu #(.RD_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .mem_addr(m_addr0), .mem_wdata(m_wdata0), .mem_store(m_store0),
    .mem_load(m_load0), .mem_rdata(m_rdata0)
  );

  lite16_lsu #(.RD_LATENCY(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .mem_addr(m_addr1), .mem_wdata(m_wdata1), .mem_store(m_store1),
    .mem_load(m_load1), .mem_rdata(m_rdata1)
  );

  // Shared request drive; sel picks which instance sees req_valid.
  int          sel = 0;
  logic        t_valid = 1'b0, t_we = 1'b0, t_byte = 1'b0, t_hi = 1'b0, t_rready = 1'b1;
  logic [15:0] t_addr = '0, t_wdata = '0;

  assign bus0.req_valid  = t_valid && (sel == 0);
  assign bus1.req_valid  = t_valid && (sel == 1);
  assign bus0.resp_ready = (sel == 0) ? t_rready : 1'b1;
  assign bus1.resp_ready = (sel == 1) ? t_rready : 1'b1;
  assign bus0.req_we = t_we;   assign bus1.req_we = t_we;
  assign bus0.req_addr = t_addr;  assign bus1.req_addr = t_addr;
  assign bus0.req_wdata = t_wdata; assign bus1.req_wdata = t_wdata;
  assign bus0.req_byte = t_byte; assign bus1.req_byte = t_byte;
  assign bus0.req_hi = t_hi;   assign bus1.req_hi = t_hi;

  logic        rq [2], rv [2], qv [2], rr [2], mld [2], mst [2];
  logic [15:0] rd [2], ma [2], mwd [2];
  assign rq[0] = bus0.req_ready;  assign rq[1] = bus1.req_ready;
  assign rv[0] = bus0.resp_valid; assign rv[1] = bus1.resp_valid;
  assign qv[0] = bus0.req_valid;  assign qv[1] = bus1.req_valid;
  assign rr[0] = bus0.resp_ready; assign rr[1] = bus1.resp_ready;
  assign rd[0] = bus0.resp_rdata; assign rd[1] = bus1.resp_rdata;
  assign mld[0] = m_load0;  assign mld[1] = m_load1;
  assign mst[0] = m_store0; assign mst[1] = m_store1;
  assign ma[0] = m_addr0;   assign ma[1] = m_addr1;
  assign mwd[0] = m_wdata0; assign mwd[1] = m_wdata1;

  // RAM per instance; read data appears RD_LATENCY edges after mem_load
  // and is poisoned with 16'hDEAD at every other time.
  logic [15:0] ram [2][65536];
  logic        pv [2][3];
  logic [15:0] pd [2][3];
  logic        pl_en = 1'b0;
  logic [15:0] pl_a = '0, pl_d = '0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pl_en) ram[d][pl_a] <= pl_d;
      else if (mst[d]) ram[d][ma[d]] <= mwd[d];
      pv[d][0] <= mld[d];
      pd[d][0] <= ram[d][ma[d]];
      for (int k = 1; k < 3; k++) begin
        pv[d][k] <= pv[d][k-1];
        pd[d][k] <= pd[d][k-1];
      end
    end
  end
  assign m_rdata0 = (pv[0][0] === 1'b1) ? pd[0][0] : 16'hDEAD;
  assign m_rdata1 = (pv[1][2] === 1'b1) ? pd[1][2] : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (one outstanding transaction per instance).
  logic [15:0] refm [2][65536];
  bit          busy [2];
  int          cyc [2], elat [2], nld [2], nst [2], xld [2], xst [2];
  int          ldp [2], stp [2];
  logic [15:0] eaddr [2], edata [2], ewdata [2];
  bit          ewr [2];
  logic [15:0] last_st_addr [2], last_st_data [2], last_ld_addr [2];

  initial begin : cmp
    bit          pre_acc [2], pre_hs [2];
    bit          byte_en;
    logic [15:0] old;
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; ldp[d] = 0; stp[d] = 0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        pre_acc[d] = qv[d] && rq[d];
        pre_hs[d]  = rv[d] && rr[d];
      end
      if (pl_en) begin
        refm[0][pl_a] = pl_d;
        refm[1][pl_a] = pl_d;
      end
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          busy[d] = 0;
        end else begin
          if (busy[d] && pre_hs[d]) begin
            chk("txn_load_pulses", 32'(nld[d]), 32'(xld[d]));
            chk("txn_store_pulses", 32'(nst[d]), 32'(xst[d]));
            if (ewr[d]) refm[d][eaddr[d]] = ewdata[d];
            busy[d] = 0;
          end
          if (pre_acc[d]) begin
`ifdef LSU_BYTE_ACCESS_EN
            byte_en = t_byte;
`else
            byte_en = 1'b0;
`endif
            old      = refm[d][t_addr];
            eaddr[d] = t_addr;
            nld[d] = 0; nst[d] = 0; cyc[d] = 1; busy[d] = 1;
            if (t_we && !byte_en) begin
              elat[d] = 2; edata[d] = 16'h0000; xld[d] = 0; xst[d] = 1;
              ewr[d] = 1; ewdata[d] = t_wdata;
            end else if (t_we) begin
              elat[d] = 4 + 2 * d; edata[d] = 16'h0000; xld[d] = 1; xst[d] = 1;
              ewr[d] = 1;
              ewdata[d] = t_hi ? {t_wdata[7:0], old[7:0]} : {old[15:8], t_wdata[7:0]};
            end else begin
              elat[d] = 3 + 2 * d; xld[d] = 1; xst[d] = 0; ewr[d] = 0;
              edata[d] = !byte_en ? old : (t_hi ? {8'h00, old[15:8]} : {8'h00, old[7:0]});
            end
          end else if (busy[d]) begin
            cyc[d]++;
          end
        end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          chk("reset_outputs", 32'({rq[d], rv[d], mld[d], mst[d]}), 32'h0);
        end else begin
          chk("load_store_exclusive", 32'(mld[d] && mst[d]), 32'h0);
          if (busy[d]) begin
            chk("req_ready_while_busy", 32'(rq[d]), 32'h0);
            chk("resp_valid_timing", 32'(rv[d]), 32'(cyc[d] >= elat[d]));
            if (rv[d]) chk("resp_rdata", 32'(rd[d]), 32'(edata[d]));
            if (mld[d]) begin
              nld[d]++; ldp[d]++; last_ld_addr[d] = ma[d];
              chk("load_addr", 32'(ma[d]), 32'(eaddr[d]));
            end
            if (mst[d]) begin
              nst[d]++; stp[d]++;
              last_st_addr[d] = ma[d]; last_st_data[d] = mwd[d];
              chk("store_addr", 32'(ma[d]), 32'(eaddr[d]));
              chk("store_data", 32'(mwd[d]), 32'(ewdata[d]));
              chk("store_after_load", 32'(nld[d]), 32'(xld[d]));
            end
          end else begin
            chk("idle_quiet", 32'({rv[d], mld[d], mst[d]}), 32'h0);
          end
        end
      end
    end
  end

  // Present a request and wait (bounded) for the accept edge.
  task automatic issue(input int d, input logic we, input logic [15:0] a, input logic [15:0] w,
                       input logic b, input logic h, output bit ok);
    @(negedge clk);
    sel = d; t_we = we; t_addr = a; t_wdata = w; t_byte = b; t_hi = h; t_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rq[d]) begin
        @(posedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1 t_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  // Full transaction; lat counts the accept edge as cycle 1.
  task automatic do_req(input int d, input logic we, input logic [15:0] a, input logic [15:0] w,
                        input logic b, input logic h, input int hold,
                        output logic [15:0] rdata, output int lat);
    bit ok, seen;
    rdata = '0; lat = 0;
    t_rready = (hold == 0);
    issue(d, we, a, w, b, h, ok);
    if (!ok) begin
      t_rready = 1'b1;
      return;
    end
    lat = 1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rv[d]) seen = 1;
    end
    if (!seen) begin
      chk("resp_timeout", 32'h0, 32'h1);
      t_rready = 1'b1;
      return;
    end
    rdata = rd[d];
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("bp_resp_valid", 32'(rv[d]), 32'h1);
        chk("bp_resp_rdata", 32'(rd[d]), 32'(rdata));
        chk("bp_req_ready", 32'(rq[d]), 32'h0);
      end
      t_rready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] r;
    int          lat, n0, n1;
    bit          ok;

    // Preload RAM and model while reset is held.
    @(negedge clk); pl_en = 1'b1; pl_a = 16'h0020; pl_d = 16'h1234;
    @(negedge clk); pl_a = 16'h0100; pl_d = 16'h0000;
    @(negedge clk); pl_en = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(rq[0]), 32'h0);
    chk("rst_mem_addr", 32'(ma[0]), 32'h0);
    chk("rst_mem_wdata", 32'(mwd[1]), 32'h0);
    chk("rst_resp_rdata", 32'(rd[0]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(rq[0]), 32'h1);

    // Word store then load.
    n1 = stp[0];
    do_req(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 0, r, lat);
    chk("wst_latency", 32'(lat), 32'd2);
    chk("wst_rdata", 32'(r), 32'h0000);
    chk("wst_pulses", 32'(stp[0] - n1), 32'd1);
    chk("wst_pulse_addr", 32'(last_st_addr[0]), 32'h0010);
    chk("wst_pulse_data", 32'(last_st_data[0]), 32'hBEEF);
    do_req(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 0, r, lat);
    chk("wld_rdata", 32'(r), 32'hBEEF);
    chk("wld_latency", 32'(lat), 32'd3);

    // Backpressure on a load.
    n0 = ldp[0];
    do_req(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 5, r, lat);
    chk("bp_rdata", 32'(r), 32'hBEEF);
    chk("bp_latency", 32'(lat), 32'd3);
    chk("bp_load_pulses", 32'(ldp[0] - n0), 32'd1);

    // RD_LATENCY = 3 instance.
    do_req(1, 1'b1, 16'h0030, 16'h1357, 1'b0, 1'b0, 0, r, lat);
    chk("l3_store_latency", 32'(lat), 32'd2);
    do_req(1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 0, r, lat);
    chk("l3_load_rdata", 32'(r), 32'h1357);
    chk("l3_load_latency", 32'(lat), 32'd5);
    do_req(1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 0, r, lat);
    chk("l3_preload_rdata", 32'(r), 32'h1234);

    // Boundary address.
    do_req(0, 1'b1, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 0, r, lat);
    chk("top_store_addr", 32'(last_st_addr[0]), 32'hFFFF);
    do_req(0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, r, lat);
    chk("top_load_addr", 32'(last_ld_addr[0]), 32'hFFFF);
    chk("top_load_rdata", 32'(r), 32'h5A5A);

`ifdef LSU_BYTE_ACCESS_EN
    n0 = ldp[0]; n1 = stp[0];
    do_req(0, 1'b1, 16'h0020, 16'h00AB, 1'b1, 1'b1, 0, r, lat);
    chk("bst_latency", 32'(lat), 32'd4);
    chk("bst_merged", 32'(last_st_data[0]), 32'hAB34);
    chk("bst_pulses", 32'({ldp[0] - n0, stp[0] - n1}), 32'({32'd1, 32'd1}));
    do_req(0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 0, r, lat);
    chk("bld_lo", 32'(r), 32'h0034);
    do_req(0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 0, r, lat);
    chk("bld_hi", 32'(r), 32'h00AB);
    do_req(1, 1'b1, 16'h0030, 16'h00CD, 1'b1, 1'b0, 0, r, lat);
    chk("l3_bst_latency", 32'(lat), 32'd6);
    do_req(1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 0, r, lat);
    chk("l3_bst_readback", 32'(r), 32'h13CD);
`else
    do_req(0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 0, r, lat);
    chk("byte_ignored_load", 32'(r), 32'h1234);
    do_req(0, 1'b1, 16'h0040, 16'hABCD, 1'b1, 1'b1, 0, r, lat);
    chk("byte_ignored_store_lat", 32'(lat), 32'd2);
    do_req(0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 0, r, lat);
    chk("byte_ignored_readback", 32'(r), 32'hABCD);
`endif

    // Reset while a store is on the RAM pins.
    issue(0, 1'b1, 16'h0100, 16'h7777, 1'b0, 1'b0, ok);
    chk("mid_store_active", 32'(mst[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_store_dropped", 32'(mst[0]), 32'h0);
    chk("mid_resp_valid", 32'(rv[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_no_resp", 32'(rv[0]), 32'h0);
    end
    chk("post_reset_ready", 32'(rq[0]), 32'h1);
    chk("abandoned_store_not_written", 32'(ram[0][16'h0100]), 32'h0000);
    do_req(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 0, r, lat);
    chk("post_reset_load", 32'(r), 32'hBEEF);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lite16_lsu.md
Name: lite16_lsu

Overview:
- Load/store unit between the LITE-16 execute stage and the data RAM.
- Accepts one memory request at a time over a valid/ready handshake.
- Drives the RAM's address, data_in, store and load pins, and waits the configured RAM read latency.
- Returns load data, or a store completion, over a valid/ready response handshake.

Parameters:
- ADDR_W, 16, width of the word address. The RAM is word-addressed with 65536 words.
- DATA_W, 16, data word width. Fixed at 16; other values are unsupported.
- RD_LATENCY, 1, number of rising clk edges from mem_load asserted to valid mem_rdata. Legal range is 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_byte  in  1  byte operation (used only with LSU_BYTE_ACCESS_EN)
- req_hi  in  1  selects the upper byte when req_byte=1
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  DATA_W  load result; 16'h0000 for stores
- mem_addr  out  ADDR_W  to RAM address
- mem_wdata  out  DATA_W  to RAM data_in
- mem_store  out  1  to RAM store
- mem_load  out  1  to RAM load
- mem_rdata  in  DATA_W  from RAM data_out

Behaviour:
- Reset: asynchronous on rst_n low, taking effect immediately.
  - State goes to IDLE.
  - req_ready, resp_valid, mem_store and mem_load go to 0.
  - mem_addr, mem_wdata, resp_rdata and the latency counter go to 0.
  - Reset mid-operation abandons the transaction. No response is ever produced for it, and mem_store drops within the same cycle.
- States: IDLE, LOAD, WAIT, STORE, RESP. All mem_* and resp_* outputs decode from registers only; there is no combinational path from req_* to mem_*.
- IDLE:
  - req_ready=1; no other state asserts req_ready.
  - On req_valid&&req_ready, latch we, addr, wdata, byte and hi.
  - Go to LOAD for a load or a byte store; go to STORE for a word store.
- LOAD: mem_load=1 for exactly one cycle, with mem_addr equal to the latched address. Load the counter with RD_LATENCY-1, then go to WAIT.
- WAIT:
  - While the counter is non-zero, decrement it.
  - When it is zero, sample mem_rdata.
  - Plain load: resp_rdata is set from mem_rdata; go to RESP.
  - Byte store: merge the byte into the latched word to form mem_wdata; go to STORE.
- STORE: mem_store=1 for exactly one cycle, with mem_addr and mem_wdata stable. Set resp_rdata=0 and go to RESP.
- RESP:
  - resp_valid=1, and resp_rdata is held stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE.
  - The next request can therefore be accepted one cycle after the response handshake at the earliest (no back-to-back overlap).
- mem_load and mem_store are never asserted in the same cycle, and are never asserted outside LOAD and STORE.
- Latency from the accept edge to resp_valid high, with RD_LATENCY=1 and resp_ready held high:
  - Word store: 2 cycles.
  - Word load: 3 cycles.
  - Byte store: 4 cycles.
  - Each additional RD_LATENCY adds 1 cycle to any path that passes through WAIT.
- Address 16'hFFFF is legal; there is no wrap or increment logic.
- req_valid while busy is ignored; the requester must hold it until req_ready.

Optional Feature:
- Macro: LSU_BYTE_ACCESS_EN.
- Defined:
  - Byte load returns the selected byte zero-extended: hi gives {8'h00, rdata[15:8]}, otherwise {8'h00, rdata[7:0]}.
  - Byte store is a read-modify-write: LOAD, WAIT, STORE, replacing only the selected byte with req_wdata[7:0].
- Not defined:
  - req_byte and req_hi are ignored, and all operations are word operations.
  - No merge or extract logic is present.

Decomposition:
- Package lite16_mem_pkg holds:
  - ADDR_W and DATA_W constants.
  - The lsu_state_t enum (IDLE, LOAD, WAIT, STORE, RESP).
  - A byte-lane select typedef.
- Sub-module lite16_lsu_byte_lane: a combinational byte extract and merge block. It is instantiated only under LSU_BYTE_ACCESS_EN.

Test Plan:
- Word store then load:
  - Store addr=16'h0010, wdata=16'hBEEF, then load 16'h0010.
  - Expect exactly one mem_store pulse with addr=16'h0010 and data=16'hBEEF.
  - Expect resp_rdata=16'hBEEF, 3 cycles after the accept edge.
- Backpressure:
  - Load, with resp_ready held low for 5 cycles.
  - resp_valid stays 1 and resp_rdata stays constant; req_ready stays 0; there are no extra mem_load pulses.
- RD_LATENCY=3:
  - Load with mem_rdata valid only 3 edges after mem_load.
  - Expect resp_valid 5 cycles after accept, with the correct data.
- Reset mid-op:
  - Assert rst_n low during STORE.
  - mem_store drops immediately, resp_valid never rises, and req_ready=1 after release.
- Byte store (macro on):
  - Memory holds 16'h1234 at 16'h0020; store byte hi with wdata=16'h00AB.
  - Expect the sequence mem_load, mem_store, with mem_wdata=16'hAB34.
  - A subsequent byte-lo load returns 16'h0034.
- Boundary address: store to and load from 16'hFFFF with 16'h5A5A returns 16'h5A5A, and mem_addr equals 16'hFFFF in both.
